// File: rtl/max_norm_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : max_norm_feeder
//  Description : Buffers one frame of signed samples while tracking the
//                frame's maximum magnitude, then replays the frame one sample
//                per cycle as (sample, max magnitude) pairs for a
//                fixed-latency divider.
//  Revision    : 1.0  initial release
// ============================================================================
module max_norm_feeder #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_rs1,
    output logic        [DATA_WIDTH-1:0] out_rs2,
    output logic                         out_last,
    output logic                         sat_seen
);

    localparam int MAG_W = DATA_WIDTH - 1;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic signed [DATA_WIDTH-1:0] c_MOST_NEG =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] c_CLAMP_NEG =
        {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t                        r_state;
    logic signed [DATA_WIDTH-1:0]  r_buf [FRAME_LEN];
    logic        [IDX_W-1:0]       r_wr_idx;
    logic        [IDX_W-1:0]       r_rd_idx;
    logic        [MAG_W-1:0]       r_max;
    logic                          r_sat_pend;

    logic                          w_accept;
    logic                          w_is_most_neg;
    logic signed [DATA_WIDTH-1:0]  w_clamped;
    logic        [MAG_W-1:0]       w_mag;
    logic        [MAG_W-1:0]       w_max_eff;

    // The block only listens for samples while filling.
    assign in_ready = (r_state == ST_FILL);

    // flush wins over acceptance so a sample presented alongside it is dropped.
    assign w_accept = in_valid && in_ready && !flush;

    // The most negative code has no positive twin; fold it one step inward so
    // every stored sample's magnitude fits in MAG_W bits.
    assign w_is_most_neg = (in_data == c_MOST_NEG);
    assign w_clamped     = w_is_most_neg ? c_CLAMP_NEG : in_data;
    assign w_mag         = w_clamped[DATA_WIDTH-1] ? MAG_W'(-w_clamped)
                                                   : w_clamped[MAG_W-1:0];

    // A zero max would make the divider divide by zero; 1 keeps quotients at 0.
    assign w_max_eff = (r_max == '0) ? MAG_W'(1) : r_max;

    // Sample storage: written at the fill index on every accepted sample.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_idx] <= w_clamped;
        end
    end

    // Fill/replay sequencer with registered divider-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_max      <= '0;
            r_sat_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_last   <= 1'b0;
            sat_seen   <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_FILL;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_max      <= '0;
            r_sat_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sat_seen   <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    // Drain edge of the previous frame: drop beat qualifiers.
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    sat_seen  <= 1'b0;
                    if (w_accept) begin
                        if (w_is_most_neg) begin
                            r_sat_pend <= 1'b1;
                        end
                        if (w_mag > r_max) begin
                            r_max <= w_mag;
                        end
                        if (r_wr_idx == c_LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_rd_idx <= '0;
                            r_state  <= ST_REPLAY;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                ST_REPLAY: begin
                    out_valid <= 1'b1;
                    out_rs1   <= r_buf[r_rd_idx];
                    out_rs2   <= {1'b0, w_max_eff};
                    out_last  <= (r_rd_idx == c_LAST_IDX);
                    // Saturation status is latched once per frame at beat 0.
                    if (r_rd_idx == '0) begin
                        sat_seen   <= r_sat_pend;
                        r_sat_pend <= 1'b0;
                    end
                    if (r_rd_idx == c_LAST_IDX) begin
                        r_rd_idx <= '0;
                        r_max    <= '0;
                        r_state  <= ST_FILL;
                    end else begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/max_norm_feeder.md
Name: max_norm_feeder

Overview:
- Upstream stage of the max-value normalization path.
- Buffers one frame of signed fixed-point samples and tracks the frame's maximum magnitude while filling.
- Replays the frame one sample per cycle as dividend/divisor pairs into fixed_point_divider: dividend = sample, divisor = frame max magnitude.
- The divider is a fixed-latency pipeline with no backpressure, so the output side is valid-only.

Parameters:
- DATA_WIDTH, 12, sample width in bits, two's complement; equals the divider IN_WIDTH.
- FRAME_LEN, 16, samples per frame; must be ≥2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort: discards the current frame and returns to FILL.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  DATA_WIDTH  signed input sample.
- out_valid  output  1  beat valid; drives divider din_valid.
- out_rs1  output  DATA_WIDTH  signed sample (divider rs1).
- out_rs2  output  DATA_WIDTH  non-negative frame max magnitude (divider rs2).
- out_last  output  1  marks the final beat of a frame.
- sat_seen  output  1  sticky per frame: at least one sample was clamped.

Behaviour:
- Reset values:
  - State FILL; in_ready=1.
  - out_valid=0, out_rs1=0, out_rs2=0, out_last=0, sat_seen=0.
  - Write index=0, max register=0.
  - Buffer contents are don't-care.
- Accept rule: a sample is captured on a rising edge where in_valid && in_ready. in_valid gaps are allowed; only accepted samples count.
- Clamp on capture:
  - -2^(DATA_WIDTH-1) is stored as -(2^(DATA_WIDTH-1)-1).
  - A clamp sets a pending saturation flag.
- Max tracking:
  - mag = |clamped sample|, DATA_WIDTH-1 bits.
  - max <= (mag > max) ? mag : max.
  - The sample accepted on the FILL→REPLAY edge is included in max.
- FSM, FILL:
  - in_ready=1.
  - The sample is written to buffer[wr_idx].
  - When the accepted sample is the FRAME_LEN-th: wr_idx wraps to 0, next state REPLAY, frame max frozen.
- FSM, REPLAY:
  - in_ready=0.
  - rd_idx runs 0..FRAME_LEN-1, one beat per cycle, no stalls.
  - Each edge registers out_valid=1, out_rs1=buffer[rd_idx], out_rs2={1'b0, max_eff}, out_last=(rd_idx==FRAME_LEN-1).
  - max_eff = max, or 1 if max==0, so an all-zero frame yields quotient 0 rather than divide-by-zero.
  - On the edge issuing the last beat: state returns to FILL, max cleared to 0, in_ready=1 in the following cycle.
- sat_seen:
  - Updated from the pending saturation flag on the edge issuing beat 0.
  - Held constant through the frame; cleared on the edge after the last beat.
- Timing (edge E0 accepts the last sample):
  - Beats k=0..FRAME_LEN-1 are registered at edges E1..E_FRAME_LEN.
  - out_valid falls at E_FRAME_LEN+1.
  - in_ready is high again after E_FRAME_LEN.
  - The earliest next-frame sample is accepted at E_FRAME_LEN+1, so frames are back-to-back with no gap beyond the drain.
- out_valid is never asserted outside REPLAY beats. out_rs2 is identical across all beats of a frame.
- flush (priority over accept and replay):
  - On the edge where flush=1: state→FILL; wr_idx, rd_idx, max and pending saturation flag cleared.
  - out_valid, out_last, sat_seen cleared on the same edge.
  - A sample presented with flush=1 is not accepted.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is lost.

Test Plan:
- FRAME_LEN=4, DATA_WIDTH=12, input 100,-300,50,200 with in_valid continuous:
  - 4 beats out_rs1=100,-300,50,200 and out_rs2=300 each.
  - out_last on the 4th beat only; sat_seen=0.
  - in_ready=0 for exactly the 4 replay cycles.
- Same frame with in_valid low on alternate cycles: identical output beats; only in_valid&&in_ready samples captured.
- Input -2048,5,6,7:
  - out_rs1=-2047,5,6,7; out_rs2=2047; sat_seen=1 for all 4 beats.
  - Next clean frame 1,2,3,4 shows sat_seen=0, out_rs2=4.
- All-zero frame: out_rs1=0×4, out_rs2=1.
- Back-to-back frames 10,20,30,40 then 1,1,1,2 fed continuously:
  - Second frame out_rs2=2 (max not carried over).
  - First sample of the second frame accepted exactly one cycle after the first frame's out_last beat.
- flush:
  - flush after 2 accepted samples, then feed 7,8,9,1: out_rs2=9; earlier samples absent.
  - flush during replay beat 1: out_valid=0 next cycle, in_ready=1, no out_last issued.
